// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and constants for the NPC load/store unit.
package ysyx_24100005_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    WB   = 2'd3
  } lsu_state_e;

  // RV32I funct3 codes; stores reuse B/H/W for SB/SH/SW.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when funct3 names a memory op this unit can execute.
  function automatic logic f3_supported(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // True when the access size does not fit its natural alignment.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_extract.sv
// Load data lane select and sign/zero extension (purely combinational).
module ysyx_24100005_lsu_extract
  import ysyx_24100005_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Extend the selected lane according to the load width and signedness.
  always_comb begin
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: one op at a time, one word-aligned bus request,
// one-cycle register-file write-back for loads.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned half/word accesses
// fault without touching the bus.
module ysyx_24100005_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [3:0]            mem_req_wmask,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  input  logic                  mem_resp_err,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  done,
  output logic                  err
);

  import ysyx_24100005_lsu_pkg::*;

  lsu_state_e            r_state;
  lsu_state_e            w_next_state;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [4:0]            r_rd;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  w_bad;
  logic [3:0]            w_st_mask;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [31:0]           w_ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_bad = !f3_supported(in_is_store, in_funct3) ||
                 f3_misaligned(in_funct3, in_addr[1:0]);
`else
  assign w_bad = !f3_supported(in_is_store, in_funct3);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; faulting ops skip the bus and go straight to WB.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = w_bad ? WB : REQ;
      REQ:     if (mem_req_ready) w_next_state = RESP;
      RESP:    if (mem_resp_valid) w_next_state = WB;
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the op on accept and the response in RESP; outputs derive from these.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 5'd0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_is_store <= in_is_store;
        r_funct3   <= in_funct3;
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_rd       <= in_rd;
        r_err      <= w_bad;
      end
      if (r_state == RESP && mem_resp_valid) begin
        r_rdata <= mem_resp_rdata;
        r_err   <= mem_resp_err;
      end
    end
  end

  // Store byte strobes and lane replication from the latched op.
  always_comb begin
    case (r_funct3)
      F3_B: begin
        w_st_mask = 4'b0001 << r_addr[1:0];
        w_st_data = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_st_mask = 4'b0011 << {r_addr[1], 1'b0};
        w_st_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_st_mask = 4'b1111;
        w_st_data = r_wdata;
      end
    endcase
  end

  ysyx_24100005_lsu_extract u_extract (
    .i_rdata  (r_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_data)
  );

  // Output decode from state and latched registers only.
  always_comb begin
    in_ready      = (r_state == IDLE) && !rst;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wmask = 4'b0000;
    mem_req_wdata = '0;
    done          = 1'b0;
    err           = 1'b0;
    rf_wen        = 1'b0;
    rf_waddr      = r_rd;
    rf_wdata      = w_ld_data;
    case (r_state)
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_req_wen   = r_is_store;
        if (r_is_store) begin
          mem_req_wmask = w_st_mask;
          mem_req_wdata = w_st_data;
        end
      end
      WB: begin
        done   = 1'b1;
        err    = r_err;
        rf_wen = !r_is_store && !r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu: directed vector table, random ops
// against a behavioural model, and a reset-during-RESP sequence.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_err(mem_resp_err),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .err(err)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        rerr;
    int          rdy_dly;
    int          resp_dly;
    logic        noreq;
    logic [31:0] e_addr;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic        e_err;
    logic [31:0] e_rf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [31:0] rdata, input logic rerr, input int rdy,
                              input int rsp, input logic noreq, input logic [31:0] e_addr,
                              input logic [3:0] e_wmask, input logic [31:0] e_wdata,
                              input logic e_err, input logic [31:0] e_rf);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.rerr = rerr; v.rdy_dly = rdy; v.resp_dly = rsp;
    v.noreq = noreq; v.e_addr = e_addr; v.e_wmask = e_wmask; v.e_wdata = e_wdata;
    v.e_err = e_err; v.e_rf = e_rf;
    return v;
  endfunction

  // Reference model: expected bus request and write-back from the op rules.
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    int     size;
    int     off;
    logic   ok;
    longint val;
    off = int'(v.addr[1:0]);
    case (int'(v.f3) % 4)
      0:       size = 1;
      1:       size = 2;
      default: size = 4;
    endcase
    if (v.st) ok = (v.f3 <= 3'd2);
    else      ok = (v.f3 <= 3'd2) || (v.f3 == 3'd4) || (v.f3 == 3'd5);
`ifdef LSU_MISALIGN_CHECK_EN
    if (off % size != 0) ok = 1'b0;
`endif
    r.noreq  = !ok;
    r.e_err  = !ok || v.rerr;
    r.e_addr = v.addr - 32'(off);
    if (size == 1) begin
      r.e_wmask = 4'(1 << off);
      r.e_wdata = (v.wdata % 32'd256) * 32'h01010101;
      val = longint'((v.rdata >> (8 * off)) % 32'd256);
      if (v.f3 < 3'd4 && val >= 128) val = val - 256;
    end else if (size == 2) begin
      r.e_wmask = 4'(3 << ((off / 2) * 2));
      r.e_wdata = (v.wdata % 32'd65536) * 32'h00010001;
      val = longint'((v.rdata >> (16 * (off / 2))) % 32'd65536);
      if (v.f3 < 3'd4 && val >= 32768) val = val - 65536;
    end else begin
      r.e_wmask = 4'hF;
      r.e_wdata = v.wdata;
      val = longint'(v.rdata);
    end
    r.e_rf = 32'(val);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_req(input vec_t v);
    check("req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr", mem_req_addr, v.e_addr);
    check("req_wen", {31'd0, mem_req_wen}, {31'd0, v.st});
    if (v.st) begin
      check("req_wmask", {28'd0, mem_req_wmask}, {28'd0, v.e_wmask});
      check("req_wdata", mem_req_wdata, v.e_wdata);
    end
  endtask

  // Run one op end to end; called at a negedge, returns at a negedge.
  task automatic do_op(input vec_t v);
    int   waited = 0;
    logic exp_wen;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; in_is_store = v.st; in_funct3 = v.f3;
    in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
    step();
    in_valid = 1'b0; in_is_store = 1'($urandom); in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    if (v.noreq) begin
      check("fault_no_req", {31'd0, mem_req_valid}, 32'd0);
      check("fault_done", {31'd0, done}, 32'd1);
      check("fault_err", {31'd0, err}, 32'd1);
      check("fault_rf_wen", {31'd0, rf_wen}, 32'd0);
      step();
      check("fault_done_pulse", {31'd0, done}, 32'd0);
      check("fault_ready_back", {31'd0, in_ready}, 32'd1);
      return;
    end
    for (int i = 0; i < v.rdy_dly; i++) begin
      check_req(v);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_done", {31'd0, done}, 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = ~v.rdata; mem_resp_err = 1'b1;
    check_req(v);
    step();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    check("resp_req_dropped", {31'd0, mem_req_valid}, 32'd0);
    for (int i = 0; i < v.resp_dly; i++) begin
      check("wait_done", {31'd0, done}, 32'd0);
      step();
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata; mem_resp_err = v.rerr;
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = $urandom; mem_resp_err = 1'b0;
    exp_wen = !v.st && !v.e_err;
    check("wb_done", {31'd0, done}, 32'd1);
    check("wb_err", {31'd0, err}, {31'd0, v.e_err});
    check("wb_rf_wen", {31'd0, rf_wen}, {31'd0, exp_wen});
    if (exp_wen) begin
      check("wb_rf_waddr", {27'd0, rf_waddr}, {27'd0, v.rd});
      check("wb_rf_wdata", rf_wdata, v.e_rf);
    end
    check("wb_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("post_done", {31'd0, done}, 32'd0);
    check("post_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  vec_t tbl[14];

  initial begin
    vec_t v;
    tbl[0]  = mk(0, 3'b010, 32'h80000004, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h80000004, 0, 0, 0, 32'hDEADBEEF);
    tbl[1]  = mk(0, 3'b000, 32'h80000003, 0, 6, 32'h80FF0000, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 32'hFFFFFF80);
    tbl[2]  = mk(0, 3'b100, 32'h80000003, 0, 7, 32'h80FF0000, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 32'h00000080);
    tbl[3]  = mk(0, 3'b101, 32'h80000002, 0, 8, 32'h80FF0000, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 32'h000080FF);
    tbl[4]  = mk(1, 3'b000, 32'h80000001, 32'h000000AB, 0, 0, 0, 0, 0, 0, 32'h80000000, 4'b0010, 32'hABABABAB, 0, 0);
    tbl[5]  = mk(1, 3'b010, 32'h80000010, 32'h12345678, 0, 0, 0, 5, 0, 0, 32'h80000010, 4'b1111, 32'h12345678, 0, 0);
    tbl[6]  = mk(0, 3'b010, 32'h80000008, 0, 9, 32'hCAFEF00D, 1, 0, 1, 0, 32'h80000008, 0, 0, 1, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[7]  = mk(0, 3'b010, 32'h80000002, 0, 10, 32'h11223344, 0, 0, 0, 1, 0, 0, 0, 1, 0);
`else
    tbl[7]  = mk(0, 3'b010, 32'h80000002, 0, 10, 32'h11223344, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 32'h11223344);
`endif
    tbl[8]  = mk(0, 3'b011, 32'h80000000, 0, 11, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 3'b100, 32'h80000000, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 3'b001, 32'h80000002, 0, 12, 32'h80010000, 0, 0, 3, 0, 32'h80000000, 0, 0, 0, 32'hFFFF8001);
    tbl[11] = mk(1, 3'b001, 32'h80000002, 32'h0000BEEF, 0, 0, 0, 1, 0, 0, 32'h80000000, 4'b1100, 32'hBEEFBEEF, 0, 0);
    tbl[12] = mk(0, 3'b010, 32'h80000000, 0, 0, 32'h00000001, 0, 0, 0, 0, 32'h80000000, 0, 0, 0, 32'h00000001);
    tbl[13] = mk(0, 3'b000, 32'h80000020, 0, 13, 32'h1234567F, 0, 2, 2, 0, 32'h80000020, 0, 0, 0, 32'h0000007F);

    rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
    in_addr = '0; in_wdata = '0; in_rd = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
    @(negedge clk);
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_req_wen", {31'd0, mem_req_wen}, 32'd0);
    check("rst_req_wmask", {28'd0, mem_req_wmask}, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_req_wdata", mem_req_wdata, 32'd0);
    check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 14; i++) do_op(tbl[i]);

    // Reset while waiting in RESP: op abandoned, late response ignored.
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h80000040; in_wdata = '0; in_rd = 5'd14;
    step();
    in_valid = 1'b0;
    check("rstseq_req", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rstseq_in_resp", {31'd0, done}, 32'd0);
    rst = 1'b1;
    step();
    check("rstseq_ready_low", {31'd0, in_ready}, 32'd0);
    check("rstseq_no_req", {31'd0, mem_req_valid}, 32'd0);
    check("rstseq_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0BAD0; mem_resp_err = 1'b0;
    #1;
    check("rstseq_idle", {31'd0, in_ready}, 32'd1);
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstseq_late_done", {31'd0, done}, 32'd0);
      check("rstseq_late_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("rstseq_late_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    do_op(tbl[0]);

    // Random ops against the reference model.
    for (int i = 0; i < 300; i++) begin
      v.st = 1'($urandom); v.f3 = 3'($urandom); v.addr = $urandom;
      v.wdata = $urandom; v.rd = 5'($urandom); v.rdata = $urandom;
      v.rerr = ($urandom_range(7) == 0); v.rdy_dly = $urandom_range(3);
      v.resp_dly = $urandom_range(3);
      do_op(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
# ysyx_24100005_lsu

Multi-cycle load/store unit between the execute stage and the register-file write port of the NPC core. It accepts one memory instruction at a time over a valid/ready handshake and issues a single word-aligned bus request. For loads it extracts and sign/zero-extends the response and drives a one-cycle register-file write (wen/waddr/wdata). Stores complete without a write-back.

## Interface
Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus/register data width; only 32 is supported

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute stage presents a memory op
- in_ready  out  1  LSU can accept; high only in IDLE
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- in_addr  in  ADDR_WIDTH  effective address
- in_wdata  in  DATA_WIDTH  store data (rs2)
- in_rd  in  5  load destination register
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_req_wen  out  1  1 = write
- mem_req_wmask  out  4  byte strobes
- mem_req_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_resp_valid  in  1  response valid (one cycle)
- mem_resp_rdata  in  DATA_WIDTH  read word
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid
- rf_wen  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  5  destination register
- rf_wdata  out  DATA_WIDTH  extended load data
- done  out  1  op complete (one-cycle pulse, loads and stores)
- err  out  1  op terminated by fault; valid with done

## Operation
- FSM states: IDLE, REQ, RESP, WB.
- IDLE: in_ready=1. On in_valid: latch is_store, funct3, addr, wdata, rd → REQ.
- REQ: mem_req_valid=1, outputs stable from latched values. On mem_req_ready → RESP. Request held indefinitely while mem_req_ready=0.
- RESP: wait for mem_resp_valid; latch rdata and err → WB. Responses arriving in IDLE/REQ/WB are ignored.
- WB (one cycle): done=1; err=latched err; rf_wen=1 only if load and not err; → IDLE.
- Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111. wdata: SB {4{b}}, SH {2{h}}, SW word.
- Load extraction: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Unsupported funct3 (load 011/110/111, store 011–111): no bus request; REQ skipped → WB with err=1, rf_wen=0.
- rf_wen may be 1 with rf_waddr=0; the register file discards it.

## Timing
- Reset values: in_ready=0 during rst, 1 the cycle after; mem_req_valid=0, mem_req_wen=0, mem_req_wmask=0, mem_req_addr=0, mem_req_wdata=0, rf_wen=0, rf_waddr=0, rf_wdata=0, done=0, err=0; state=IDLE.
- All outputs are registered or decoded from state/latched regs only; there is no combinational path from in_* or mem_resp_* to outputs.
- Minimum latency, zero-wait bus: accept at T0, req at T1 (ready at T1), resp at T2, done/rf_wen at T3. Next accept at T4.
- rst mid-operation: immediate return to IDLE, outstanding request dropped, no done/rf_wen. The bus fabric is reset on the same rst.
- mem_resp_valid in the same cycle as mem_req_ready is ignored. A response is expected no earlier than one cycle later.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issues no bus request and goes IDLE→WB with err=1, rf_wen=0.
- Undefined: no check. Misaligned halves use half-select addr[1]. Misaligned words access the aligned word containing addr. done with err=0.

## Structure
- Package ysyx_24100005_lsu_pkg: state enum (IDLE/REQ/RESP/WB), funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
- Sub-module ysyx_24100005_lsu_extract: combinational load select/extend (rdata, addr[1:0], funct3 → 32-bit result). The store strobe/replication logic stays in the top.

## Test plan
- LW addr 0x80000004, rd=5, rdata 0xDEADBEEF, zero-wait → mem_req_addr 0x80000004, wen=0; at T3 rf_wen=1, rf_waddr=5, rf_wdata 0xDEADBEEF, done=1.
- LB addr 0x80000003, rdata 0x80FF_0000 → rf_wdata 0xFFFFFF80. LBU with the same inputs → 0x00000080. LHU addr 0x…2 → 0x000080FF.
- SB addr 0x80000001, wdata 0x000000AB → wmask 4'b0010, wdata 0xABABABAB, wen=1; done=1, rf_wen=0.
- mem_req_ready low 5 cycles → mem_req_valid held with stable addr/data, in_ready=0 throughout. resp_err=1 → done=1, err=1, rf_wen=0.
- LW addr 0x80000002: with LSU_MISALIGN_CHECK_EN, no mem_req_valid, done/err=1 at T1. Without it, request addr 0x80000000, err=0.
- rst asserted in RESP → next cycle state IDLE, a late mem_resp_valid is ignored, no done/rf_wen pulse.
